// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller-to-datapath/instruction-memory signal bundle
interface multicycle_ctrl_if;
    logic [4:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       ir_ld;
    logic       pc_we;
    logic       pc_sel;
    logic       rf_we;
    logic       retire;
    logic       halted;
    logic       err;

    modport master (
        output opcode, zero, mem_ready,
        input  mem_req, ir_ld, pc_we, pc_sel, rf_we, retire, halted, err
    );

    modport slave (
        input  opcode, zero, mem_ready,
        output mem_req, ir_ld, pc_we, pc_sel, rf_we, retire, halted, err
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM (IDLE/FETCH/DECODE/EXEC/WB/HALT/ERR)
// Optional FETCH wait timeout enabled by defining FETCH_TIMEOUT_EN.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
    } state_t;

    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b11011;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b00000;

    state_t state_q, state_d;
    logic   mem_req, ir_ld, pc_we, pc_sel, rf_we, retire, halted, err;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt_q <= '0;
        else      wait_cnt_q <= wait_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        ir_ld   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        rf_we   = 1'b0;
        retire  = 1'b0;
        halted  = 1'b0;
        err     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end
`ifdef FETCH_TIMEOUT_EN
                else begin
                    // Error is taken on the wait cycle that brings the count to TIMEOUT.
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TIMEOUT_CNT) state_d = S_ERR;
                end
`endif
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (bus.opcode)
                    OP_ADDI, OP_XOR: state_d = S_WB;
                    OP_BEQZ: begin
                        pc_we   = 1'b1;
                        pc_sel  = bus.zero;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            S_ERR:    err    = 1'b1;
            default:  state_d = S_ERR;
        endcase
    end

    assign bus.mem_req = mem_req;
    assign bus.ir_ld   = ir_ld;
    assign bus.pc_we   = pc_we;
    assign bus.pc_sel  = pc_sel;
    assign bus.rf_we   = rf_we;
    assign bus.retire  = retire;
    assign bus.halted  = halted;
    assign bus.err     = err;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning maximum consecutive FETCH wait cycles before error (1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port opcode  input  5  instr[15:11] from instruction register.
REQ-005 SHALL have port zero  input  1  high when read1data == 16'h0000.
REQ-006 SHALL have port mem_ready  input  1  instruction memory data valid this cycle.
REQ-007 SHALL have port mem_req  output  1  instruction fetch request.
REQ-008 SHALL have port ir_ld  output  1  load instruction register.
REQ-009 SHALL have port pc_we  output  1  PC write enable.
REQ-010 SHALL have port pc_sel  output  1  0 = PC+2, 1 = PC+2+imm.
REQ-011 SHALL have port rf_we  output  1  register file write enable.
REQ-012 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-013 SHALL have port halted  output  1  sticky halt indication.
REQ-014 SHALL have port err  output  1  sticky error indication.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR; all outputs decoded from registered state plus the inputs named below.
REQ-016 SHALL go IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-017 SHALL drive mem_req=1 in FETCH only; ir_ld=1 in FETCH only when mem_ready=1, in that case moving to DECODE; otherwise staying in FETCH.
REQ-018 SHALL go DECODE -> EXEC unconditionally (one cycle for register read).
REQ-019 In EXEC SHALL decode opcode: 01000 (ADDI) or 11011 (XOR) -> WB; 01100 (BEQZ) -> FETCH with pc_we=1, pc_sel=zero, retire=1; 00000 (HALT) -> HALT with retire=1; any other value -> ERR.
REQ-020 In WB SHALL assert rf_we=1, pc_we=1, pc_sel=0, retire=1, then go to FETCH.
REQ-021 SHALL give minimum latency from FETCH entry to retire: 4 cycles for ADDI/XOR, 3 for BEQZ/HALT, each extended by one cycle per mem_ready=0 FETCH cycle.
REQ-022 SHALL hold HALT and ERR until reset; halted=1 only in HALT, err=1 only in ERR; all other outputs 0 in both.
REQ-023 SHALL never assert rf_we and pc_sel=1 together, nor pc_we outside WB or BEQZ EXEC.
REQ-024 SHALL sample mem_ready on the edge concluding each FETCH cycle; mem_ready outside FETCH SHALL be ignored.

Reset
REQ-025 SHALL place state in IDLE immediately on rst low, independent of clk, including mid-FETCH or mid-WB.
REQ-026 SHALL drive every output to 0 while rst is low and in IDLE; wait counter SHALL clear to 0.
REQ-027 SHALL restart fetching only via IDLE -> FETCH after rst returns high.

Configuration
REQ-028 With FETCH_TIMEOUT_EN defined, SHALL count consecutive FETCH cycles with mem_ready=0 (8-bit counter, cleared on FETCH exit or mem_ready=1) and go to ERR on the cycle the count reaches TIMEOUT.
REQ-029 Without FETCH_TIMEOUT_EN, SHALL contain no wait counter and wait in FETCH indefinitely; ERR then reachable only through illegal opcode.

Verification
REQ-030 Reset release, mem_ready=1 always, opcode=01000 -> mem_req cycle 1, ir_ld cycle 1, rf_we+pc_we+retire on cycle 4, pc_sel=0, back to FETCH cycle 5.
REQ-031 opcode=01100, zero=1 -> pc_we=1, pc_sel=1, retire=1 in EXEC (cycle 3), rf_we never 1; zero=0 -> pc_sel=0.
REQ-032 mem_ready low 3 cycles then high, opcode=11011 -> ir_ld on 4th FETCH cycle, retire 7 cycles after FETCH entry.
REQ-033 opcode=00000 -> halted=1 from next cycle, stays 1 for 20 cycles, mem_req=0; opcode=10101 -> err=1 sticky.
REQ-034 FETCH_TIMEOUT_EN defined, TIMEOUT=15, mem_ready held 0 -> err=1 after 15 wait cycles; undefined -> mem_req stays 1 for 100 cycles, err=0.
REQ-035 rst driven low mid-WB between clock edges -> all outputs 0 immediately; after release, FETCH resumes with retire count restarting.
